// File: rtl/duc_upconverter_pkg.sv
// duc_upconverter_pkg: shared widths and types for the digital up-converter.
//   LUT_IDX_W   - carrier phase bits that address the sin/cos table
//   LUT_MAG_W   - unsigned magnitude width held in the table (1..12)
//   LUT_VAL_W   - signed table output width (+-12)
//   DEF_*       - default NCO and baseband widths
package duc_upconverter_pkg;
  localparam int LUT_IDX_W       = 6;
  localparam int LUT_MAG_W       = 4;
  localparam int LUT_VAL_W       = LUT_MAG_W + 1;
  localparam int DEF_PHASE_WIDTH = 32;
  localparam int DEF_IQ_WIDTH    = 4;

  typedef logic signed [LUT_VAL_W-1:0] trig_t;
endpackage

// File: rtl/duc_upconverter_if.sv
// duc_upconverter_if: control, baseband and IF bundle for duc_upconverter.
//   master - sample/control source (drives *_i, reads *_o)
//   slave  - the up-converter itself
interface duc_upconverter_if #(
  parameter int PHASE_WIDTH = 32,
  parameter int IQ_WIDTH    = 4,
  parameter int OUT_WIDTH   = IQ_WIDTH + 5
);
  logic                        enable_i;
  logic [PHASE_WIDTH-1:0]      carrier_freq_i;
  logic                        phase_load_i;
  logic [PHASE_WIDTH-1:0]      phase_init_i;
  logic                        sample_valid_i;
  logic signed [IQ_WIDTH-1:0]  sample_i_i;
  logic signed [IQ_WIDTH-1:0]  sample_q_i;
  logic                        if_valid_o;
  logic signed [OUT_WIDTH-1:0] if_data_o;
  logic [PHASE_WIDTH-1:0]      phase_o;

  modport master (
    output enable_i, carrier_freq_i, phase_load_i, phase_init_i,
           sample_valid_i, sample_i_i, sample_q_i,
    input  if_valid_o, if_data_o, phase_o
  );

  modport slave (
    input  enable_i, carrier_freq_i, phase_load_i, phase_init_i,
           sample_valid_i, sample_i_i, sample_q_i,
    output if_valid_o, if_data_o, phase_o
  );
endinterface

// File: rtl/duc_sincos_lut.sv
// duc_sincos_lut: combinational 6-bit phase -> signed sin/cos (+-12).
//   i_phase - top 6 bits of the carrier phase
//   o_sin   - signed sine sample
//   o_cos   - signed cosine sample
// A 16-entry quarter-wave table is mirrored by p[4]; quadrant signs come
// from p[5] (sin) and p[5]^p[4] (cos). Same quantisation as the DDC.
module duc_sincos_lut
  import duc_upconverter_pkg::*;
(
  input  logic [LUT_IDX_W-1:0] i_phase,
  output trig_t                o_sin,
  output trig_t                o_cos
);
  logic [3:0]           w_addr;
  logic [LUT_MAG_W-1:0] w_sin_mag;
  logic [LUT_MAG_W-1:0] w_cos_mag;
  logic [LUT_VAL_W-1:0] w_sin_u;
  logic [LUT_VAL_W-1:0] w_cos_u;

  assign w_addr = i_phase[4] ? ~i_phase[3:0] : i_phase[3:0];

  always_comb begin
    w_sin_mag = 4'd1;
    w_cos_mag = 4'd12;
    case (w_addr)
      4'd0:  begin w_sin_mag = 4'd1;  w_cos_mag = 4'd12; end
      4'd1:  begin w_sin_mag = 4'd2;  w_cos_mag = 4'd12; end
      4'd2:  begin w_sin_mag = 4'd3;  w_cos_mag = 4'd12; end
      4'd3:  begin w_sin_mag = 4'd4;  w_cos_mag = 4'd11; end
      4'd4:  begin w_sin_mag = 4'd5;  w_cos_mag = 4'd11; end
      4'd5:  begin w_sin_mag = 4'd6;  w_cos_mag = 4'd10; end
      4'd6:  begin w_sin_mag = 4'd7;  w_cos_mag = 4'd10; end
      4'd7:  begin w_sin_mag = 4'd8;  w_cos_mag = 4'd9;  end
      4'd8:  begin w_sin_mag = 4'd9;  w_cos_mag = 4'd8;  end
      4'd9:  begin w_sin_mag = 4'd10; w_cos_mag = 4'd7;  end
      4'd10: begin w_sin_mag = 4'd10; w_cos_mag = 4'd6;  end
      4'd11: begin w_sin_mag = 4'd11; w_cos_mag = 4'd5;  end
      4'd12: begin w_sin_mag = 4'd11; w_cos_mag = 4'd4;  end
      4'd13: begin w_sin_mag = 4'd12; w_cos_mag = 4'd3;  end
      4'd14: begin w_sin_mag = 4'd12; w_cos_mag = 4'd2;  end
      default: begin w_sin_mag = 4'd12; w_cos_mag = 4'd1; end
    endcase
  end

  assign w_sin_u = {1'b0, w_sin_mag};
  assign w_cos_u = {1'b0, w_cos_mag};

  assign o_sin = i_phase[5]              ? trig_t'(5'd0 - w_sin_u) : trig_t'(w_sin_u);
  assign o_cos = (i_phase[5] ^ i_phase[4]) ? trig_t'(5'd0 - w_cos_u) : trig_t'(w_cos_u);
endmodule

// File: rtl/duc_upconverter.sv
// duc_upconverter: 32-bit NCO + I*cos - Q*sin real IF generator.
//   clk, rst   - clock, async active-high reset
//   bus.slave  - enable, carrier word, phase load/init, baseband I/Q strobe
//                in; IF valid/data and accumulator value out
// Pipeline: accept edge -> stage1 (trig, I, Q) -> products -> IF register.
// Output valid rises in the cycle after the second edge following accept.
// enable_i low zeroes the valid chain (in-flight samples dropped) while
// data registers keep their contents.
module duc_upconverter
  import duc_upconverter_pkg::*;
#(
  parameter int PHASE_WIDTH = DEF_PHASE_WIDTH,
  parameter int IQ_WIDTH    = DEF_IQ_WIDTH,
  parameter int OUT_WIDTH   = IQ_WIDTH + 5
) (
  input  logic            clk,
  input  logic            rst,
  duc_upconverter_if.slave bus
);
  localparam int STAGES = 2;

  logic                        w_accept;
  logic [PHASE_WIDTH-1:0]      w_eff_phase;
  trig_t                       w_sin;
  trig_t                       w_cos;
  logic signed [OUT_WIDTH-1:0] w_icos;
  logic signed [OUT_WIDTH-1:0] w_qsin;

  logic [PHASE_WIDTH-1:0]      r_acc;
  logic [STAGES:0]             r_vld_pipe;
  trig_t                       r_s1_sin;
  trig_t                       r_s1_cos;
  logic signed [IQ_WIDTH-1:0]  r_s1_i;
  logic signed [IQ_WIDTH-1:0]  r_s1_q;
  logic signed [OUT_WIDTH-1:0] r_p_icos;
  logic signed [OUT_WIDTH-1:0] r_p_qsin;
  logic signed [OUT_WIDTH-1:0] r_if_data;

  assign w_accept    = bus.enable_i & bus.sample_valid_i;
  // A load strobe coincident with an accept applies to that very sample.
  assign w_eff_phase = bus.phase_load_i ? bus.phase_init_i : r_acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   r_acc <= '0;
    else if (w_accept)         r_acc <= w_eff_phase + bus.carrier_freq_i;
    else if (bus.phase_load_i) r_acc <= bus.phase_init_i;
  end

  duc_sincos_lut u_lut (
    .i_phase (w_eff_phase[PHASE_WIDTH-1 -: LUT_IDX_W]),
    .o_sin   (w_sin),
    .o_cos   (w_cos)
  );

  // Sign-extend both operands to the output width; |I*trig| <= 96 fits.
  assign w_icos = OUT_WIDTH'(r_s1_i) * OUT_WIDTH'(r_s1_cos);
  assign w_qsin = OUT_WIDTH'(r_s1_q) * OUT_WIDTH'(r_s1_sin);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_pipe <= '0;
      r_s1_sin   <= '0;
      r_s1_cos   <= '0;
      r_s1_i     <= '0;
      r_s1_q     <= '0;
      r_p_icos   <= '0;
      r_p_qsin   <= '0;
      r_if_data  <= '0;
    end else begin
      r_vld_pipe <= bus.enable_i ? {r_vld_pipe[STAGES-1:0], w_accept} : '0;
      if (w_accept) begin
        r_s1_sin <= w_sin;
        r_s1_cos <= w_cos;
        r_s1_i   <= bus.sample_i_i;
        r_s1_q   <= bus.sample_q_i;
      end
      if (bus.enable_i && r_vld_pipe[0]) begin
        r_p_icos <= w_icos;
        r_p_qsin <= w_qsin;
      end
      if (bus.enable_i && r_vld_pipe[1])
        r_if_data <= r_p_icos - r_p_qsin;
    end
  end

  assign bus.if_valid_o = r_vld_pipe[STAGES];
  assign bus.if_data_o  = r_if_data;
  assign bus.phase_o    = r_acc;
endmodule

// File: tb/tb_duc_upconverter.sv
// tb_duc_upconverter: directed vectors with a queue scoreboard; a negedge
// monitor pops one expected IF value per valid output.
module tb_duc_upconverter;
  localparam int PW  = 32;
  localparam int IQW = 4;
  localparam int OW  = IQW + 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  duc_upconverter_if #(.PHASE_WIDTH(PW), .IQ_WIDTH(IQW), .OUT_WIDTH(OW)) bus ();

  duc_upconverter #(.PHASE_WIDTH(PW), .IQ_WIDTH(IQW), .OUT_WIDTH(OW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int n_out  = 0;
  int exp_q[$];
  int mon_exp;
  int out_mark;

  int sin_m[16] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 10, 11, 11, 12, 12, 12};
  int cos_m[16] = '{12, 12, 12, 11, 11, 10, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1};

  function automatic int model(input int p, input int i, input int q);
    int a, s, c, quad;
    quad = p / 16;              // 0..3
    a    = (quad % 2 == 1) ? 15 - (p % 16) : (p % 16);
    s    = (quad >= 2) ? -sin_m[a] : sin_m[a];
    c    = (quad == 1 || quad == 2) ? -cos_m[a] : cos_m[a];
    return i * c - q * s;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic ld, input logic [PW-1:0] init, input logic v,
                       input int i, input int q);
    bus.phase_load_i   = ld;
    bus.phase_init_i   = init;
    bus.sample_valid_i = v;
    bus.sample_i_i     = IQW'(i);
    bus.sample_q_i     = IQW'(q);
    @(posedge clk); #1;
    bus.phase_load_i   = 1'b0;
    bus.sample_valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (bus.if_valid_o) begin
      n_out++;
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_out: got %0d expected none", int'(bus.if_data_o));
      end else begin
        mon_exp = exp_q.pop_front();
        check("if_data", longint'(bus.if_data_o), longint'(mon_exp));
      end
    end
  end

  initial begin
    bus.enable_i       = 1'b0;
    bus.carrier_freq_i = '0;
    bus.phase_load_i   = 1'b0;
    bus.phase_init_i   = '0;
    bus.sample_valid_i = 1'b0;
    bus.sample_i_i     = '0;
    bus.sample_q_i     = '0;

    #2;
    check("rst_valid", longint'(bus.if_valid_o), 0);
    check("rst_data",  longint'(bus.if_data_o), 0);
    check("rst_phase", longint'(bus.phase_o), 0);
    @(negedge clk); rst = 1'b0;
    idle(1);

    // cos(0) = +12
    bus.enable_i = 1'b1;
    drive(1'b1, 32'h0000_0000, 1'b1, 3, 0); exp_q.push_back(36);
    check("phase_zero_freq", longint'(bus.phase_o), 0);
    idle(4);

    // p=010000: sin +12, cos -1
    drive(1'b1, 32'h4000_0000, 1'b1, 1, 1);  exp_q.push_back(-13);
    drive(1'b1, 32'h4000_0000, 1'b1, -8, 7); exp_q.push_back(-76);
    idle(4);

    // p=110000 -> a=15: sin -12, cos +1
    drive(1'b1, 32'hC000_0000, 1'b1, 0, -8); exp_q.push_back(-96);
    idle(4);

    // accumulator wrap; p=111111 -> sin -1, cos +12
    bus.carrier_freq_i = 32'h0000_0020;
    drive(1'b1, 32'hFFFF_FFF0, 1'b1, 2, 3); exp_q.push_back(27);
    check("phase_wrap", longint'(bus.phase_o), longint'(32'h0000_0010));
    idle(4);

    // full-circle sweep, back-to-back
    bus.carrier_freq_i = 32'h0400_0000;
    drive(1'b1, 32'h0000_0000, 1'b0, 0, 0);
    check("phase_load_only", longint'(bus.phase_o), 0);
    out_mark = n_out;
    for (int k = 0; k < 64; k++) begin
      drive(1'b0, '0, 1'b1, (k % 16) - 8, 7 - (k % 16));
      exp_q.push_back(model(k, (k % 16) - 8, 7 - (k % 16)));
    end
    check("sweep_phase_back_to_0", longint'(bus.phase_o), 0);
    idle(4);
    check("sweep_out_count", longint'(n_out - out_mark), 64);

    // enable drop after third accept: only the first sample emerges
    bus.carrier_freq_i = 32'h0100_0000;
    drive(1'b1, 32'h1000_0000, 1'b0, 0, 0);
    drive(1'b0, '0, 1'b1, 1, 1); exp_q.push_back(6);
    drive(1'b0, '0, 1'b1, 2, 2);
    drive(1'b0, '0, 1'b1, 3, 3);
    bus.enable_i       = 1'b0;
    bus.sample_valid_i = 1'b1;   // ignored while disabled
    idle(4);
    bus.sample_valid_i = 1'b0;
    check("phase_frozen", longint'(bus.phase_o), longint'(32'h1300_0000));
    check("drop_queue_empty", longint'(exp_q.size()), 0);
    bus.enable_i = 1'b1;
    idle(2);

    // load + accept together: sin -1, cos -12
    bus.carrier_freq_i = 32'h0000_0100;
    drive(1'b1, 32'h8000_0000, 1'b1, 2, 3); exp_q.push_back(-21);
    check("phase_load_accept", longint'(bus.phase_o), longint'(32'h8000_0100));
    idle(4);

    // reset mid-pipeline: nothing emerges
    drive(1'b0, '0, 1'b1, 5, 5);
    idle(1);
    #3; rst = 1'b1; #1;
    check("midrst_valid", longint'(bus.if_valid_o), 0);
    check("midrst_phase", longint'(bus.phase_o), 0);
    check("midrst_data",  longint'(bus.if_data_o), 0);
    @(negedge clk); rst = 1'b0;
    idle(4);

    check("final_queue_empty", longint'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
